fp_issue_ctrl: RTL and testbench
================================

// Module: fp_issue_ctrl
// PURPOSE
//   Issue-side sequencer for the FP add/sub unit (fp_01). Accepts operation requests on a valid/ready port
//   and drives the FPU's en/op/a/b pins. Waits for the FPU's out_final (fpu_done), then captures c into
//   a small response FIFO read over a second valid/ready port. A watchdog retires hung operations.
// PARAMETERS
//   TIMEOUT_CYCLES  64  max WAIT cycles before an op is retired as timed out (>=2)
//   FIFO_DEPTH      4   response FIFO entries (power of two, >=2)
// PORTS
//   clk          in   1   clock, all flops rising edge
//   reset        in   1   asynchronous, active-low reset
//   req_valid    in   1   request present
//   req_ready    out  1   request accepted when req_valid & req_ready at posedge
//   req_op       in   1   0=add, 1=sub (passed to FPU op)
//   req_a        in   32  IEEE-754 single operand a
//   req_b        in   32  IEEE-754 single operand b
//   fpu_en       out  1   FPU enable
//   fpu_op       out  1   latched op
//   fpu_a        out  32  latched operand a
//   fpu_b        out  32  latched operand b
//   fpu_c        in   32  FPU result
//   fpu_done     in   1   FPU out_final; result valid on fpu_c this cycle
//   rsp_valid    out  1   FIFO non-empty
//   rsp_ready    in   1   consumer pops head when rsp_valid & rsp_ready
//   rsp_c        out  32  head result
//   rsp_timeout  out  1   head entry was a timeout (rsp_c = 32'h7FC00000)
//   busy         out  1   FSM not in IDLE
// BEHAVIOUR
//   Reset (async, while reset=0): FSM=IDLE.
//     Outputs fpu_en=0, fpu_op=0, fpu_a=fpu_b=0, busy=0, rsp_valid=0, rsp_c=0, rsp_timeout=0.
//     FIFO pointers/count=0, watchdog=0. Reset mid-op discards the in-flight op and all queued responses.
//   FSM states:
//     IDLE: req_ready = (count < FIFO_DEPTH). On accept: latch op/a/b into fpu_* -> ISSUE.
//     ISSUE: fpu_en=1 for this cycle -> WAIT. Watchdog cleared.
//     WAIT: fpu_en=1, fpu_* held stable; watchdog++ each cycle.
//       If fpu_done=1: push {timeout=0, fpu_c} -> RECOVER.
//       Else if watchdog==TIMEOUT_CYCLES-1: push {timeout=1, 32'h7FC00000} -> RECOVER.
//       fpu_done and timeout in the same cycle: fpu_done wins.
//     RECOVER: fpu_en=0 for exactly one cycle (lets FPU control return to idle) -> IDLE.
//   Handshakes:
//     req_ready=0 outside IDLE; one op in flight max.
//     fpu_done outside WAIT is ignored (no push).
//     rsp_* must not depend combinationally on rsp_ready.
//   Latency: accept at edge N -> fpu_en high N+1.. -> done seen in cycle D -> rsp_valid high at D+1 (if FIFO was empty).
//     Back-to-back accept at earliest D+2.
//     Minimum request-to-request spacing: 4 cycles.
//   FIFO:
//     Circular, log2(FIFO_DEPTH)-bit pointers wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//     Push and pop in the same cycle: count unchanged, both pointers advance.
//     Push never occurs when full (IDLE gating guarantees a slot). Pop when empty is ignored.
//     rsp_c/rsp_timeout reflect the head entry; they are 0 when empty.
// TESTING
//   add 3F800000+40000000, fpu_done 3 cycles after fpu_en -> rsp_c=40400000, rsp_timeout=0, fpu_en low 1 cycle after done.
//   rsp_ready=0, issue 4 ops -> count=4, req_ready=0 with req_valid=1; one pop -> req_ready=1 next cycle.
//   fpu_done never asserted -> after 64 WAIT cycles rsp_c=7FC00000, rsp_timeout=1, FSM back to IDLE 1 cycle later.
//   fpu_done on the same cycle watchdog hits 63 -> real fpu_c pushed, rsp_timeout=0.
//   FIFO 3 entries, push+pop same cycle -> count stays 3; write pointer wraps 3->0 with order preserved.
//   reset low during WAIT -> fpu_en=0, rsp_valid=0, busy=0 immediately; first op after release completes normally.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issue-side sequencer for the FP add/sub unit.
//   Accepts one request at a time (req_valid/req_ready) and holds the FPU
//   operands and enable stable until the FPU reports fpu_done. It then drops
//   fpu_en for one cycle so the FPU control can return to idle.
//   Results, or a quiet-NaN marker when the watchdog fires, are queued in a
//   small response FIFO that is drained over rsp_valid/rsp_ready.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_op/req_a/req_b : request port
//   fpu_en/fpu_op/fpu_a/fpu_b/fpu_c/fpu_done : FPU pins
//   rsp_valid/rsp_ready/rsp_c/rsp_timeout   : response port (FIFO head)
//   busy : sequencer is not idle
module fp_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        fpu_en,
    output logic        fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic [31:0] fpu_c,
    input  logic        fpu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW:0]   DEPTH   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER} state_e;

    typedef struct packed {
        logic        timeout;
        logic [31:0] c;
    } rsp_t;

    state_e        state_q, state_d;
    logic          op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    rsp_t          mem_q [FIFO_DEPTH];
    rsp_t          mem_d [FIFO_DEPTH];
    logic          push, pop;
    rsp_t          push_data;
    rsp_t          head;

    // Only accept when a FIFO slot is guaranteed, so a push can never overflow.
    assign req_ready = (state_q == S_IDLE) && (count_q < DEPTH);
    assign fpu_en    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign fpu_op    = op_q;
    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign busy      = (state_q != S_IDLE);

    // Sequencer
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        wd_d      = wd_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WW'(1);
                // A real result beats the watchdog when both land together.
                if (fpu_done) begin
                    push      = 1'b1;
                    push_data = '{timeout: 1'b0, c: fpu_c};
                    state_d   = S_RECOVER;
                end else if (wd_q == WD_LAST) begin
                    push      = 1'b1;
                    push_data = '{timeout: 1'b1, c: QNAN};
                    state_d   = S_RECOVER;
                end
            end
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Response FIFO
    always_comb begin
        pop     = rsp_ready && (count_q != '0);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
        if (push && !pop)      count_d = count_q + (PW + 1)'(1);
        else if (!push && pop) count_d = count_q - (PW + 1)'(1);
    end

    // Head is masked to zero when empty; no path from rsp_ready.
    assign rsp_valid   = (count_q != '0);
    assign head        = rsp_valid ? mem_q[rd_q] : '0;
    assign rsp_c       = head.c;
    assign rsp_timeout = head.timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl (TIMEOUT_CYCLES=64, FIFO_DEPTH=4).
module tb_fp_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_op;
    logic [31:0] req_a, req_b;
    logic        fpu_en, fpu_op;
    logic [31:0] fpu_a, fpu_b, fpu_c;
    logic        fpu_done;
    logic        rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [31:0] rsp_c;

    int total = 0;
    int bad   = 0;

    fp_issue_ctrl #(.TIMEOUT_CYCLES(64), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .fpu_en(fpu_en), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_c(fpu_c), .fpu_done(fpu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for req_ready, accept it.
    // Returns in the ISSUE cycle.
    task automatic accept(input logic op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        while (!req_ready && n < 20) begin tick(); n++; end
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // From the ISSUE cycle: nwait WAIT cycles without done, then done with c.
    // Optionally pop in the done cycle. Returns in the IDLE cycle after RECOVER.
    task automatic complete(input int nwait, input logic [31:0] c, input bit pop_now);
        tick();
        repeat (nwait) tick();
        fpu_done = 1'b1; fpu_c = c; rsp_ready = pop_now;
        tick();
        fpu_done = 1'b0; rsp_ready = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] c, input logic to);
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_c"}, rsp_c, c);
        check({tag, "_to"}, {31'b0, rsp_timeout}, {31'b0, to});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
        fpu_c = '0; fpu_done = 1'b0; rsp_ready = 1'b0;
        tick(); tick();

        // ---- reset state
        check("rst_fpu_en", {31'b0, fpu_en}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_c", rsp_c, 32'd0);
        check("rst_rsp_to", {31'b0, rsp_timeout}, 32'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        check("rst_fpu_op", {31'b0, fpu_op}, 32'd0);
        reset = 1'b1;
        tick();

        // ---- 1.0 + 2.0, done 3 cycles after fpu_en rises
        accept(1'b0, 32'h3F80_0000, 32'h4000_0000);
        check("t1_issue_en", {31'b0, fpu_en}, 32'd1);
        check("t1_fpu_a", fpu_a, 32'h3F80_0000);
        check("t1_fpu_b", fpu_b, 32'h4000_0000);
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_ready_low", {31'b0, req_ready}, 32'd0);
        tick(); tick(); tick();
        check("t1_wait_en", {31'b0, fpu_en}, 32'd1);
        check("t1_no_rsp_yet", {31'b0, rsp_valid}, 32'd0);
        fpu_done = 1'b1; fpu_c = 32'h4040_0000;
        tick();
        fpu_done = 1'b0; fpu_c = 32'hDEAD_BEEF;
        check("t1_recover_en", {31'b0, fpu_en}, 32'd0);
        check("t1_recover_busy", {31'b0, busy}, 32'd1);
        check("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("t1_rsp_c", rsp_c, 32'h4040_0000);
        check("t1_rsp_to", {31'b0, rsp_timeout}, 32'd0);
        tick();
        check("t1_idle_busy", {31'b0, busy}, 32'd0);
        check("t1_idle_ready", {31'b0, req_ready}, 32'd1);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("t1_drained", {31'b0, rsp_valid}, 32'd0);
        check("t1_empty_c", rsp_c, 32'd0);
        // stray done while idle must not push
        fpu_done = 1'b1; fpu_c = 32'h1111_1111; tick(); fpu_done = 1'b0;
        check("stray_done", {31'b0, rsp_valid}, 32'd0);
        check("stray_busy", {31'b0, busy}, 32'd0);

        // ---- fill the FIFO with no consumer
        accept(1'b1, 32'h1, 32'h2); check("t2_sub_op", {31'b0, fpu_op}, 32'd1);
        complete(0, 32'hA000_0001, 1'b0);
        accept(1'b0, 32'h3, 32'h4); complete(1, 32'hA000_0002, 1'b0);
        accept(1'b0, 32'h5, 32'h6); complete(0, 32'hA000_0003, 1'b0);
        accept(1'b0, 32'h7, 32'h8); complete(2, 32'hA000_0004, 1'b0);
        req_valid = 1'b1; req_a = 32'h9;
        check("t2_full_ready", {31'b0, req_ready}, 32'd0);
        tick();
        check("t2_full_no_accept", {31'b0, busy}, 32'd0);
        check("t2_head", rsp_c, 32'hA000_0001);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        check("t2_ready_after_pop", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        pop_expect("t2_e2", 32'hA000_0002, 1'b0);
        pop_expect("t2_e3", 32'hA000_0003, 1'b0);
        pop_expect("t2_e4", 32'hA000_0004, 1'b0);
        check("t2_empty", {31'b0, rsp_valid}, 32'd0);

        // ---- watchdog: fpu_done never comes
        accept(1'b0, 32'h4120_0000, 32'h4130_0000);
        tick();
        repeat (63) tick();
        check("t3_last_wait_en", {31'b0, fpu_en}, 32'd1);
        check("t3_last_wait_norsp", {31'b0, rsp_valid}, 32'd0);
        tick();
        check("t3_recover_en", {31'b0, fpu_en}, 32'd0);
        check("t3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("t3_rsp_c", rsp_c, 32'h7FC0_0000);
        check("t3_rsp_to", {31'b0, rsp_timeout}, 32'd1);
        check("t3_recover_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t3_idle", {31'b0, busy}, 32'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // ---- done on the watchdog's final cycle: real result wins
        accept(1'b0, 32'h1, 32'h1);
        tick();
        repeat (63) tick();
        fpu_done = 1'b1; fpu_c = 32'h1234_5678;
        tick();
        fpu_done = 1'b0;
        check("t4_rsp_c", rsp_c, 32'h1234_5678);
        check("t4_rsp_to", {31'b0, rsp_timeout}, 32'd0);
        tick();
        pop_expect("t4_pop", 32'h1234_5678, 1'b0);

        // ---- three queued, push+pop in one cycle, pointer wrap, order kept
        accept(1'b0, 32'h0, 32'h0); complete(0, 32'hB000_000A, 1'b0);
        accept(1'b0, 32'h0, 32'h0); complete(0, 32'hB000_000B, 1'b0);
        accept(1'b0, 32'h0, 32'h0); complete(0, 32'hB000_000C, 1'b0);
        accept(1'b0, 32'h0, 32'h0); complete(1, 32'hB000_000D, 1'b1);
        check("t5_head_after_pp", rsp_c, 32'hB000_000B);
        check("t5_count3_ready", {31'b0, req_ready}, 32'd1);
        accept(1'b0, 32'h0, 32'h0); complete(0, 32'hB000_000E, 1'b0);
        check("t5_full_ready", {31'b0, req_ready}, 32'd0);
        pop_expect("t5_b", 32'hB000_000B, 1'b0);
        pop_expect("t5_c", 32'hB000_000C, 1'b0);
        pop_expect("t5_d", 32'hB000_000D, 1'b0);
        pop_expect("t5_e", 32'hB000_000E, 1'b0);
        check("t5_empty", {31'b0, rsp_valid}, 32'd0);

        // ---- reset during WAIT with a queued response
        accept(1'b0, 32'h0, 32'h0); complete(0, 32'hC000_0001, 1'b0);
        accept(1'b1, 32'h4040_0000, 32'h3F80_0000);
        tick(); tick();
        reset = 1'b0;
        #1;
        check("t6_rst_en", {31'b0, fpu_en}, 32'd0);
        check("t6_rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_c", rsp_c, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        accept(1'b1, 32'h4040_0000, 32'h3F80_0000);
        check("t6_op", {31'b0, fpu_op}, 32'd1);
        complete(2, 32'h4000_0000, 1'b0);
        pop_expect("t6_after", 32'h4000_0000, 1'b0);
        check("t6_empty", {31'b0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
